// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: opcodes and FSM state encoding shared by the UART command path
package uart_cmd_pkg;
   localparam logic [7:0] CMD_WR    = 8'hAA;
   localparam logic [7:0] CMD_RD    = 8'hBB;
   localparam logic [7:0] NACK_BYTE = 8'hEE;
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_ADDR = 3'd1;
   localparam logic [2:0] WR_DATA = 3'd2;
   localparam logic [2:0] RD_ADDR = 3'd3;
   localparam logic [2:0] RD_WAIT = 3'd4;
   localparam logic [2:0] SEND    = 3'd5;
endpackage

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes UART write/read command frames into register-file strobes and returns read data or NACK
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] CMD_WR    = uart_cmd_pkg::CMD_WR,
   parameter logic [DATA_WIDTH-1:0] CMD_RD    = uart_cmd_pkg::CMD_RD,
   parameter logic [DATA_WIDTH-1:0] NACK_BYTE = uart_cmd_pkg::NACK_BYTE
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic                  RX_ERR,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Valid,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_busy,
   output logic                  frame_abort
);
   logic [2:0] state;
   logic       receiving;
   logic       rx_bad;
   logic       rx_ok;

   assign receiving = (state == IDLE) || (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);
   assign rx_bad    = receiving && RX_D_VLD && RX_ERR;
   assign rx_ok     = RX_D_VLD && !RX_ERR;

   // frame FSM; strobes default low so each asserts for exactly one cycle
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         WrEn        <= 1'b0;
         RdEn        <= 1'b0;
         Address     <= '0;
         WrData      <= '0;
         TX_P_DATA   <= '0;
         TX_D_VLD    <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         WrEn        <= 1'b0;
         RdEn        <= 1'b0;
         frame_abort <= rx_bad;
         if (rx_bad) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE:
                  if (rx_ok) begin
                     if (RX_P_DATA == CMD_WR) begin
                        state <= WR_ADDR;
                     end else if (RX_P_DATA == CMD_RD) begin
                        state <= RD_ADDR;
                     end else begin
                        TX_P_DATA <= NACK_BYTE;
                        TX_D_VLD  <= !TX_busy;
                        state     <= SEND;
                     end
                  end
               WR_ADDR:
                  if (rx_ok) begin
                     Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                     state   <= WR_DATA;
                  end
               WR_DATA:
                  if (rx_ok) begin
                     WrData <= RX_P_DATA;
                     WrEn   <= 1'b1;
                     state  <= IDLE;
                  end
               RD_ADDR:
                  if (rx_ok) begin
                     Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                     RdEn    <= 1'b1;
                     state   <= RD_WAIT;
                  end
               RD_WAIT:
                  if (RdData_Valid) begin
                     TX_P_DATA <= RdData;
                     TX_D_VLD  <= !TX_busy;
                     state     <= SEND;
                  end
               SEND:
                  if (TX_D_VLD && TX_busy) begin
                     TX_D_VLD <= 1'b0;
                     state    <= IDLE;
                  end else if (!TX_D_VLD) begin
                     TX_D_VLD <= !TX_busy;
                  end
               default:
                  state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: scoreboard bench for uart_cmd_ctrl with register-file and UART transmitter models
module tb_uart_cmd_ctrl;
   localparam int K_WR = 1;
   localparam int K_RD = 2;
   localparam int K_AB = 3;
   localparam int K_TX = 4;

   typedef struct {
      int kind;
      int addr;
      int data;
      int due;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] RX_P_DATA = '0;
   logic       RX_D_VLD = 1'b0;
   logic       RX_ERR = 1'b0;
   logic       WrEn;
   logic       RdEn;
   logic [3:0] Address;
   logic [7:0] WrData;
   logic [7:0] RdData = '0;
   logic       RdData_Valid = 1'b0;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_busy = 1'b0;
   logic       frame_abort;

   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [7:0] exp_regs[16];
   logic [7:0] regs[16];
   bit         hold_busy = 1'b0;
   int         busy_cnt = 0;
   int         rd_cnt = 0;
   logic [3:0] rd_addr = '0;
   logic       prev_vld = 1'b0;
   logic       last_busy = 1'b0;
   logic [7:0] prev_data = '0;

   uart_cmd_ctrl dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
      .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData), .RdData(RdData),
      .RdData_Valid(RdData_Valid), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .TX_busy(TX_busy), .frame_abort(frame_abort)
   );

   always #5 CLK = ~CLK;

   // cycle stamp used to check strobe latency
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input int addr, input int data);
      exp_t e;
      if (sb.size() == 0) begin
         chk("unexpected_event", kind, 0);
         return;
      end
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      if (kind != e.kind) return;
      if (kind != K_TX) chk("ev_cycle", cyc, e.due);
      if (kind == K_WR || kind == K_RD) chk("ev_addr", addr, e.addr);
      if (kind == K_WR || kind == K_TX) chk("ev_data", data, e.data);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      RX_ERR    = e;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      RX_ERR    = 1'b0;
   endtask

   task automatic frame_wr(input logic [7:0] a, input logic [7:0] d);
      send_byte(8'hAA, 1'b0);
      send_byte(a, 1'b0);
      exp_regs[a[3:0]] = d;
      sb.push_back('{K_WR, int'(a[3:0]), int'(d), cyc + 1});
      send_byte(d, 1'b0);
   endtask

   task automatic frame_rd(input logic [7:0] a);
      send_byte(8'hBB, 1'b0);
      sb.push_back('{K_RD, int'(a[3:0]), 0, cyc + 1});
      sb.push_back('{K_TX, 0, int'(exp_regs[a[3:0]]), 0});
      send_byte(a, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      chk("drain", sb.size(), 0);
      repeat (6) @(negedge CLK);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_wren"}, WrEn, 0);
      chk({tag, "_rden"}, RdEn, 0);
      chk({tag, "_addr"}, Address, 0);
      chk({tag, "_wrdata"}, WrData, 0);
      chk({tag, "_txdata"}, TX_P_DATA, 0);
      chk({tag, "_txvld"}, TX_D_VLD, 0);
      chk({tag, "_abort"}, frame_abort, 0);
   endtask

   // output monitor, register-file responder and UART transmitter model
   initial begin
      forever begin
         @(negedge CLK);
         if (RST) begin
            if (WrEn) expect_ev(K_WR, Address, WrData);
            if (RdEn) expect_ev(K_RD, Address, 0);
            if (frame_abort) expect_ev(K_AB, 0, 0);
            if (TX_D_VLD && !prev_vld) begin
               chk("tx_rise_busy", last_busy, 0);
               expect_ev(K_TX, 0, TX_P_DATA);
            end
            if (TX_D_VLD && prev_vld) chk("tx_stable", TX_P_DATA, prev_data);
            if (prev_vld && last_busy) chk("tx_drop", TX_D_VLD, 0);
         end
         prev_vld  = TX_D_VLD;
         prev_data = TX_P_DATA;
         if (WrEn) regs[Address] = WrData;
         RdData_Valid = 1'b0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               RdData_Valid = 1'b1;
               RdData = regs[rd_addr];
            end
         end
         if (RdEn) begin
            rd_cnt  = 2;
            rd_addr = Address;
         end
         if (hold_busy) begin
            TX_busy = 1'b1;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            TX_busy = (busy_cnt != 0);
         end else if (TX_D_VLD) begin
            TX_busy  = 1'b1;
            busy_cnt = 3;
         end else begin
            TX_busy = 1'b0;
         end
         last_busy = TX_busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         regs[i] = '0;
         exp_regs[i] = '0;
      end
      #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk_outputs_zero("reset");
      RST = 1'b1;
      @(negedge CLK);
      frame_wr(8'h05, 8'h3C);
      drain();
      frame_rd(8'h05);
      drain();
      sb.push_back('{K_TX, 0, 32'hEE, 0});
      send_byte(8'h12, 1'b0);
      drain();
      send_byte(8'hAA, 1'b0);
      send_byte(8'h05, 1'b0);
      sb.push_back('{K_AB, 0, 0, cyc + 1});
      send_byte(8'h3C, 1'b1);
      frame_wr(8'h06, 8'h77);
      drain();
      chk("regs5_kept", exp_regs[5], 8'h3C);
      sb.push_back('{K_AB, 0, 0, cyc + 1});
      send_byte(8'hBB, 1'b1);
      frame_rd(8'h06);
      drain();
      send_byte(8'hBB, 1'b0);
      sb.push_back('{K_AB, 0, 0, cyc + 1});
      send_byte(8'h06, 1'b1);
      drain();
      frame_wr(8'hF9, 8'hA5);
      frame_rd(8'h19);
      drain();
      frame_rd(8'h05);
      send_byte(8'hAA, 1'b0);
      drain();
      frame_wr(8'h02, 8'h11);
      frame_rd(8'h02);
      drain();
      hold_busy = 1'b1;
      @(negedge CLK);
      frame_rd(8'h06);
      repeat (25) @(negedge CLK);
      chk("tx_held_low", TX_D_VLD, 0);
      hold_busy = 1'b0;
      drain();
      send_byte(8'hBB, 1'b0);
      sb.push_back('{K_RD, 7, 0, cyc + 1});
      send_byte(8'h07, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      #1 chk_outputs_zero("midreset");
      @(negedge CLK);
      RST = 1'b1;
      repeat (10) @(negedge CLK);
      chk("no_tx_after_rst", TX_D_VLD, 0);
      chk("rst_sb_empty", sb.size(), 0);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] a;
         logic [7:0] d;
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom);
         frame_wr(a, d);
         frame_rd({4'($urandom_range(0, 15)), a[3:0]});
         drain();
      end
      chk("final_sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Byte-level command controller on the system side of the UART. It consumes received bytes from the UART receiver, decodes write and read command frames, and drives the register-file port. It returns read data, or a NACK byte, through the UART transmitter. The block sits between the UART (after the clock-domain pulse synchronisers) and the register file, all in the system clock domain.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width on every data path
- ADDR_WIDTH, 4, register-file address width; address taken from the low ADDR_WIDTH bits of the address byte
- CMD_WR, 8'hAA, write command opcode
- CMD_RD, 8'hBB, read command opcode
- NACK_BYTE, 8'hEE, byte returned for an unknown opcode

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid
- RX_ERR  in  1  parity or framing error on the byte qualified by the same RX_D_VLD
- WrEn  out  1  register write strobe, one cycle
- RdEn  out  1  register read strobe, one cycle
- Address  out  ADDR_WIDTH  register address
- WrData  out  DATA_WIDTH  register write data
- RdData  in  DATA_WIDTH  register read data
- RdData_Valid  in  1  RdData valid, one cycle, ≥1 cycle after RdEn
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  transmit request, level
- TX_busy  in  1  UART transmitter busy (synchronised)
- frame_abort  out  1  one-cycle pulse when a frame is discarded

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, SEND.
- IDLE, RX_D_VLD:
  - CMD_WR → WR_ADDR
  - CMD_RD → RD_ADDR
  - any other opcode → latch NACK_BYTE into tx byte, go to SEND
- WR_ADDR, RX_D_VLD: latch address → WR_DATA.
- WR_DATA, RX_D_VLD: drive WrEn=1 with Address and WrData=RX_P_DATA for one cycle → IDLE. Writes produce no response.
- RD_ADDR, RX_D_VLD: latch address, pulse RdEn one cycle → RD_WAIT.
- RD_WAIT, RdData_Valid: latch RdData → SEND.
- SEND:
  - TX_D_VLD=1 with TX_P_DATA stable until TX_busy is sampled high (byte accepted), then → IDLE.
  - If TX_busy is already high on entry, wait for it to fall, then raise TX_D_VLD.
  - RX bytes arriving in SEND or RD_WAIT are dropped.
- RX_ERR with RX_D_VLD in any receiving state (IDLE, WR_ADDR, WR_DATA, RD_ADDR):
  - byte ignored, no strobe issued
  - frame_abort pulses
  - state → IDLE
- Address and WrData hold their last values between strobes.

## Timing
- Reset values: WrEn=0, RdEn=0, Address=0, WrData=0, TX_P_DATA=0, TX_D_VLD=0, frame_abort=0, state=IDLE.
- All outputs are registered.
- WrEn asserts the cycle after the data byte's RX_D_VLD.
- RdEn asserts the cycle after the address byte's RX_D_VLD.
- TX_D_VLD asserts the cycle after RdData_Valid is sampled, or after the unknown opcode is sampled, provided TX_busy=0.
- TX_D_VLD deasserts the cycle after TX_busy=1 is sampled.
- RdData_Valid outside RD_WAIT is ignored.
- Reset mid-frame: immediate return to IDLE, all outputs cleared, partial frame lost, no strobe emitted.
- Back-to-back frames: the next opcode is accepted on the cycle state returns to IDLE. No bubble is required beyond the FSM transition.

## Structure
- Shared package uart_cmd_pkg holds:
  - opcode constants CMD_WR, CMD_RD, NACK_BYTE
  - state encoding (binary, 3 bits)
- Single module; no sub-module needed. An optional transmit-request holder (uart_tx_req) may be split out if reused by other system-side blocks.

## Test plan
- Write frame AA,05,3C → one WrEn pulse with Address=5, WrData=8'h3C; no TX_D_VLD.
- Read frame BB,05, RdData=3C returned 2 cycles after RdEn → RdEn pulse with Address=5; TX_D_VLD with TX_P_DATA=8'h3C held until TX_busy=1, then low.
- Unknown opcode 8'h12 → TX_P_DATA=8'hEE sent once; no WrEn/RdEn.
- AA,05 then a data byte with RX_ERR=1 → frame_abort pulse, no WrEn; following frame AA,06,77 writes Address=6, WrData=8'h77.
- Read with TX_busy held high for 20 cycles on entry to SEND → TX_D_VLD stays 0 until TX_busy falls, then the byte is sent exactly once.
- RST low during RD_WAIT → all outputs 0 immediately; a late RdData_Valid produces no TX_D_VLD.
